// File: rtl/rv32v_types_pkg.sv
// ----------------------------------------------------------------------------
// rv32v_types_pkg
//   Shared types for the vector load-store path.
//   NUM_LANES    : lanes per vector memory beat
//   vseq_state_t : vector memory sequencer FSM states
//   vmem_eew_t   : element width encoding from vector issue
//   load_t       : LSC load type (RISC-V funct3 encoding, reused as store size)
//   eew_to_load  : element width -> zero-extending load type
// ----------------------------------------------------------------------------
package rv32v_types_pkg;

   localparam int unsigned NUM_LANES = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2,
      FAULT = 2'd3
   } vseq_state_t;

   typedef enum logic [1:0] {
      EEW8     = 2'b00,
      EEW16    = 2'b01,
      EEW32    = 2'b10,
      EEW_RSVD = 2'b11
   } vmem_eew_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_t;

   // The reserved width is handled as a full word.
   function automatic load_t eew_to_load(input vmem_eew_t eew);
      load_t lt;
      case (eew)
         EEW8:    lt = LBU;
         EEW16:   lt = LHU;
         default: lt = LW;
      endcase
      return lt;
   endfunction

endpackage

// File: rtl/rv32v_lane_addr_gen.sv
// ----------------------------------------------------------------------------
// rv32v_lane_addr_gen
//   Combinational per-lane address and lane-enable generation for one beat.
//   lane_base_i : byte address of lane 0 in the current beat
//   stride_i    : byte stride between consecutive elements (two's complement)
//   beat_i      : current beat index
//   vl_i        : element count of the instruction
//   addr_o      : per-lane byte addresses, lane i at [i*32 +: 32]
//   ven_o       : lane i enabled when its element index is below vl
// ----------------------------------------------------------------------------
module rv32v_lane_addr_gen #(
   parameter int unsigned NUM_LANES = 4,
   parameter int unsigned VL_W      = 6
) (
   input  logic [31:0]             lane_base_i,
   input  logic [31:0]             stride_i,
   input  logic [VL_W-1:0]         beat_i,
   input  logic [VL_W-1:0]         vl_i,
   output logic [NUM_LANES*32-1:0] addr_o,
   output logic [NUM_LANES-1:0]    ven_o
);

   always_comb begin
      addr_o = '0;
      ven_o  = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++) begin
         // 32-bit arithmetic: wraps silently, negative strides work as two's complement
         addr_o[i*32 +: 32] = lane_base_i + stride_i * i;
         ven_o[i]           = (32'(beat_i) * NUM_LANES + i) < 32'(vl_i);
      end
   end

endmodule

// File: rtl/rv32v_lsc_sequencer.sv
// ----------------------------------------------------------------------------
// rv32v_lsc_sequencer
//   Breaks one unit-stride or strided vector load/store into NUM_LANES-wide
//   beats toward the load-store controller, returns load data per beat and
//   reports completion or a misaligned-address fault.
//   Request side : req_valid/req_ready handshake, req_store, req_base,
//                  req_stride, req_vl, req_eew
//   Store data   : st_data for the beat named by st_beat (combinational)
//   LSC side     : lsc_ren/lsc_wen, lsc_addr_wide, lsc_ven_lanes,
//                  lsc_load_type, lsc_store_data; lsc_ready, lsc_mal_addr,
//                  lsc_dload_wide returned
//   Writeback    : wb_valid pulse with wb_beat, wb_data, wb_mask
//   Status       : done / fault pulses, fault_beat held until next accept
// ----------------------------------------------------------------------------
module rv32v_lsc_sequencer
   import rv32v_types_pkg::*;
#(
   parameter int unsigned NUM_LANES = rv32v_types_pkg::NUM_LANES,
   parameter int unsigned VL_W      = 6
) (
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_store,
   input  logic [31:0]             req_base,
   input  logic [31:0]             req_stride,
   input  logic [VL_W-1:0]         req_vl,
   input  logic [1:0]              req_eew,
   input  logic [NUM_LANES*32-1:0] st_data,
   output logic [VL_W-1:0]         st_beat,
   output logic                    lsc_ren,
   output logic                    lsc_wen,
   output logic [NUM_LANES*32-1:0] lsc_addr_wide,
   output logic [NUM_LANES-1:0]    lsc_ven_lanes,
   output load_t                   lsc_load_type,
   output logic [NUM_LANES*32-1:0] lsc_store_data,
   input  logic                    lsc_ready,
   input  logic                    lsc_mal_addr,
   input  logic [NUM_LANES*32-1:0] lsc_dload_wide,
   output logic                    wb_valid,
   output logic [VL_W-1:0]         wb_beat,
   output logic [NUM_LANES*32-1:0] wb_data,
   output logic [NUM_LANES-1:0]    wb_mask,
   output logic                    done,
   output logic                    fault,
   output logic [VL_W-1:0]         fault_beat
);

   vseq_state_t               state_q, state_d;
   logic                      store_q;
   logic [31:0]               stride_q;
   logic [31:0]               lane_base_q;
   logic [VL_W-1:0]           vl_q;
   logic [VL_W-1:0]           beat_q;
   vmem_eew_t                 eew_q;
   logic [VL_W-1:0]           fault_beat_q;
   logic                      wb_valid_q;
   logic [VL_W-1:0]           wb_beat_q;
   logic [NUM_LANES*32-1:0]   wb_data_q;
   logic [NUM_LANES-1:0]      wb_mask_q;

   logic [NUM_LANES*32-1:0]   addr;
   logic [NUM_LANES-1:0]      ven;
   logic                      issuing;
   logic                      accept;
   logic                      beat_ok;
   logic                      beat_bad;
   logic [VL_W-1:0]           vl_m1;
   logic [VL_W-1:0]           last_beat;
   logic                      is_last;

   rv32v_lane_addr_gen #(
      .NUM_LANES (NUM_LANES),
      .VL_W      (VL_W)
   ) u_addr_gen (
      .lane_base_i (lane_base_q),
      .stride_i    (stride_q),
      .beat_i      (beat_q),
      .vl_i        (vl_q),
      .addr_o      (addr),
      .ven_o       (ven)
   );

   assign issuing  = (state_q == ISSUE);
   assign accept   = req_valid && req_ready;
   assign beat_ok  = issuing && lsc_ready && !lsc_mal_addr;
   assign beat_bad = issuing && lsc_ready &&  lsc_mal_addr;

   // Last beat = ceil(vl/NUM_LANES)-1 = (vl-1)/NUM_LANES; vl is nonzero in ISSUE.
   assign vl_m1     = vl_q - VL_W'(1);
   assign last_beat = VL_W'(32'(vl_m1) / NUM_LANES);
   assign is_last   = (beat_q == last_beat);

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = (req_vl == '0) ? DONE : ISSUE;
         ISSUE:   begin
                     if (beat_bad)                 state_d = FAULT;
                     else if (beat_ok && is_last)  state_d = DONE;
                  end
         DONE:    state_d = IDLE;
         FAULT:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q      <= IDLE;
         store_q      <= 1'b0;
         stride_q     <= '0;
         lane_base_q  <= '0;
         vl_q         <= '0;
         beat_q       <= '0;
         eew_q        <= EEW8;
         fault_beat_q <= '0;
         wb_valid_q   <= 1'b0;
         wb_beat_q    <= '0;
         wb_data_q    <= '0;
         wb_mask_q    <= '0;
      end else begin
         state_q    <= state_d;
         wb_valid_q <= 1'b0;
         if (accept) begin
            store_q      <= req_store;
            stride_q     <= req_stride;
            vl_q         <= req_vl;
            eew_q        <= vmem_eew_t'(req_eew);
            lane_base_q  <= req_base;
            beat_q       <= '0;
            fault_beat_q <= '0;
         end
         if (beat_ok) begin
            beat_q      <= beat_q + VL_W'(1);
            lane_base_q <= lane_base_q + stride_q * NUM_LANES;
            if (!store_q) begin
               wb_valid_q <= 1'b1;
               wb_beat_q  <= beat_q;
               wb_data_q  <= lsc_dload_wide;
               wb_mask_q  <= ven;
            end
         end
         if (beat_bad) fault_beat_q <= beat_q;
      end
   end

   // req_ready is held low while reset is asserted so every output reads 0 in reset.
   assign req_ready     = (state_q == IDLE) && !RST;
   assign lsc_ren       = issuing && !store_q;
   assign lsc_wen       = issuing &&  store_q;
   assign lsc_addr_wide = addr;
   assign lsc_ven_lanes = issuing ? ven : '0;
   assign lsc_load_type = issuing ? eew_to_load(eew_q) : LB;
   assign st_beat       = beat_q;

   always_comb begin
      lsc_store_data = '0;
      for (int unsigned i = 0; i < NUM_LANES; i++)
         lsc_store_data[i*32 +: 32] = lsc_ven_lanes[i] ? st_data[i*32 +: 32] : 32'h0;
   end

   assign wb_valid   = wb_valid_q;
   assign wb_beat    = wb_beat_q;
   assign wb_data    = wb_data_q;
   assign wb_mask    = wb_mask_q;
   assign done       = (state_q == DONE);
   assign fault      = (state_q == FAULT);
   assign fault_beat = fault_beat_q;

endmodule

// File: tb/tb_rv32v_lsc_sequencer.sv
// ----------------------------------------------------------------------------
// tb_rv32v_lsc_sequencer
//   Directed scoreboard bench for rv32v_lsc_sequencer: stimulus pushes the
//   expected beat requests, writebacks and completion events; a monitor on
//   the falling edge pops and compares whenever the DUT presents them.
// ----------------------------------------------------------------------------
module tb_rv32v_lsc_sequencer;
   import rv32v_types_pkg::*;

   localparam int unsigned NL  = 4;
   localparam int unsigned VLW = 6;

   logic             CLK, RST;
   logic             req_valid, req_ready, req_store;
   logic [31:0]      req_base, req_stride;
   logic [VLW-1:0]   req_vl;
   logic [1:0]       req_eew;
   logic [NL*32-1:0] st_data;
   logic [VLW-1:0]   st_beat;
   logic             lsc_ren, lsc_wen;
   logic [NL*32-1:0] lsc_addr_wide;
   logic [NL-1:0]    lsc_ven_lanes;
   load_t            lsc_load_type;
   logic [NL*32-1:0] lsc_store_data;
   logic             lsc_ready, lsc_mal_addr;
   logic [NL*32-1:0] lsc_dload_wide;
   logic             wb_valid;
   logic [VLW-1:0]   wb_beat;
   logic [NL*32-1:0] wb_data;
   logic [NL-1:0]    wb_mask;
   logic             done, fault;
   logic [VLW-1:0]   fault_beat;

   rv32v_lsc_sequencer #(.NUM_LANES(NL), .VL_W(VLW)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
      .req_base(req_base), .req_stride(req_stride), .req_vl(req_vl), .req_eew(req_eew),
      .st_data(st_data), .st_beat(st_beat),
      .lsc_ren(lsc_ren), .lsc_wen(lsc_wen), .lsc_addr_wide(lsc_addr_wide),
      .lsc_ven_lanes(lsc_ven_lanes), .lsc_load_type(lsc_load_type),
      .lsc_store_data(lsc_store_data), .lsc_ready(lsc_ready), .lsc_mal_addr(lsc_mal_addr),
      .lsc_dload_wide(lsc_dload_wide),
      .wb_valid(wb_valid), .wb_beat(wb_beat), .wb_data(wb_data), .wb_mask(wb_mask),
      .done(done), .fault(fault), .fault_beat(fault_beat)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic         st;
      logic [127:0] addr;
      logic [3:0]   ven;
      logic [2:0]   lt;
      logic [5:0]   beat;
      logic [127:0] sdata;
   } req_t;
   typedef struct {
      logic [5:0]   beat;
      logic [127:0] data;
      logic [3:0]   mask;
   } wb_t;
   typedef struct {
      logic       is_fault;
      logic [5:0] beat;
   } ev_t;

   req_t exp_req[$];
   wb_t  exp_wb[$];
   ev_t  exp_ev[$];
   req_t mr;
   wb_t  mw;
   ev_t  me;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [127:0] m_addr(input logic [31:0] base, input logic [31:0] stride, input int b);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[i*32 +: 32] = base + 32'(b*4 + i) * stride;
      return r;
   endfunction

   function automatic logic [3:0] m_ven(input int b, input int vl);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ((b*4 + i) < vl);
      return r;
   endfunction

   function automatic logic [2:0] m_lt(input logic [1:0] eew);
      case (eew)
         2'b00:   return 3'b100;
         2'b01:   return 3'b101;
         default: return 3'b010;
      endcase
   endfunction

   function automatic logic [127:0] pat(input int b, input logic st);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[i*32 +: 32] = (st ? 32'h5700_0000 : 32'hD000_0000) + 32'(b*256 + i + 1);
      return r;
   endfunction

   function automatic logic [127:0] mask_data(input logic [127:0] d, input logic [3:0] v);
      logic [127:0] r;
      for (int i = 0; i < 4; i++) r[i*32 +: 32] = v[i] ? d[i*32 +: 32] : 32'h0;
      return r;
   endfunction

   // ---------------- monitor ----------------
   always @(negedge CLK) begin
      if (!RST) begin
         if ((lsc_ren || lsc_wen) && lsc_ready) begin
            if (exp_req.size() == 0) begin
               total++; bad++;
               $display("FAIL unexp_req actual=beat %0d required=none", st_beat);
            end else begin
               mr = exp_req.pop_front();
               chk("req_kind",  {lsc_ren, lsc_wen}, mr.st ? 2'b01 : 2'b10);
               chk("req_addr",  lsc_addr_wide, mr.addr);
               chk("req_ven",   lsc_ven_lanes, mr.ven);
               chk("req_ltype", lsc_load_type, mr.lt);
               chk("req_beat",  st_beat, mr.beat);
               if (mr.st) chk("req_sdata", lsc_store_data, mr.sdata);
            end
         end
         if (wb_valid) begin
            if (exp_wb.size() == 0) begin
               total++; bad++;
               $display("FAIL unexp_wb actual=beat %0d required=none", wb_beat);
            end else begin
               mw = exp_wb.pop_front();
               chk("wb_beat", wb_beat, mw.beat);
               chk("wb_data", wb_data, mw.data);
               chk("wb_mask", wb_mask, mw.mask);
            end
         end
         if (done || fault) begin
            if (exp_ev.size() == 0) begin
               total++; bad++;
               $display("FAIL unexp_event actual=done%0b/fault%0b required=none", done, fault);
            end else begin
               me = exp_ev.pop_front();
               chk("ev_fault", fault, me.is_fault);
               chk("ev_done",  done, !me.is_fault);
               if (me.is_fault) chk("ev_fault_beat", fault_beat, me.beat);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 50) begin
         @(posedge CLK); #1; n++;
      end
      chk("req_ready_wait", req_ready, 1'b1);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_req.size() + exp_wb.size() + exp_ev.size()) != 0 && n < 20) begin
         @(posedge CLK); #1; n++;
      end
      chk("drain", exp_req.size() + exp_wb.size() + exp_ev.size(), 0);
   endtask

   task automatic accept(input logic st, input logic [31:0] base, input logic [31:0] stride,
                         input int vl, input logic [1:0] eew);
      wait_ready();
      req_store = st; req_base = base; req_stride = stride;
      req_vl = 6'(vl); req_eew = eew; req_valid = 1'b1;
      @(posedge CLK); #1;
      req_valid = 1'b0;
   endtask

   task automatic run_op(input logic st, input logic [31:0] base, input logic [31:0] stride,
                         input int vl, input logic [1:0] eew,
                         input int stall_b, input int stall_n, input int fault_b,
                         input logic chk_b0, input logic [127:0] b0_addr);
      int nb, last;
      req_t r;
      wb_t  w;
      ev_t  e;
      nb   = (vl + 3) / 4;
      last = (fault_b >= 0 && fault_b < nb) ? fault_b : nb - 1;
      for (int b = 0; b <= last; b++) begin
         r.st = st; r.addr = m_addr(base, stride, b); r.ven = m_ven(b, vl);
         r.lt = m_lt(eew); r.beat = 6'(b); r.sdata = mask_data(pat(b, 1'b1), r.ven);
         exp_req.push_back(r);
         if (!st && b != fault_b) begin
            w.beat = 6'(b); w.data = pat(b, 1'b0); w.mask = r.ven;
            exp_wb.push_back(w);
         end
      end
      e.is_fault = (fault_b >= 0 && fault_b < nb);
      e.beat     = e.is_fault ? 6'(fault_b) : 6'd0;
      exp_ev.push_back(e);

      accept(st, base, stride, vl, eew);
      if (vl == 0) begin
         chk("vl0_done", done, 1'b1);
         chk("vl0_no_req", {lsc_ren, lsc_wen}, 2'b00);
         @(posedge CLK); #1;
         chk("vl0_no_req2", {lsc_ren, lsc_wen}, 2'b00);
         chk("vl0_ready", req_ready, 1'b1);
         drain();
         return;
      end
      if (chk_b0) chk("b0_addr_hand", lsc_addr_wide, b0_addr);

      for (int b = 0; b <= last; b++) begin
         if (b == stall_b) begin
            for (int s = 0; s < stall_n; s++) begin
               lsc_ready = 1'b0;
               @(negedge CLK);
               chk("bp_addr", lsc_addr_wide, m_addr(base, stride, b));
               chk("bp_ven",  lsc_ven_lanes, m_ven(b, vl));
               chk("bp_req",  {lsc_ren, lsc_wen}, st ? 2'b01 : 2'b10);
               chk("bp_beat", st_beat, 6'(b));
               @(posedge CLK); #1;
            end
         end
         lsc_ready      = 1'b1;
         lsc_mal_addr   = (b == fault_b);
         lsc_dload_wide = pat(b, 1'b0);
         st_data        = pat(b, 1'b1);
         @(posedge CLK); #1;
      end
      lsc_ready = 1'b0; lsc_mal_addr = 1'b0;

      if (e.is_fault) begin
         chk("flt_pulse", fault, 1'b1);
         chk("flt_beat",  fault_beat, 6'(fault_b));
         chk("flt_no_next_req", {lsc_ren, lsc_wen}, 2'b00);
         @(posedge CLK); #1;
         chk("flt_ready_back", req_ready, 1'b1);
         chk("flt_one_cycle", fault, 1'b0);
         chk("flt_beat_held", fault_beat, 6'(fault_b));
      end else begin
         chk("done_timing", done, 1'b1);
         chk("done_no_req", {lsc_ren, lsc_wen}, 2'b00);
      end
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

   initial begin
      RST = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_base = '0; req_stride = '0;
      req_vl = '0; req_eew = '0; st_data = '0; lsc_ready = 1'b0; lsc_mal_addr = 1'b0;
      lsc_dload_wide = '0;

      #12;
      chk("rst_req_ready", req_ready, 1'b0);
      chk("rst_ren_wen",   {lsc_ren, lsc_wen}, 2'b00);
      chk("rst_status",    {wb_valid, done, fault}, 3'b000);
      chk("rst_fault_beat", fault_beat, 6'd0);
      @(negedge CLK); RST = 1'b0; #1;
      chk("rst_release_ready", req_ready, 1'b1);
      @(posedge CLK); #1;

      // unit-stride word load, two full beats
      run_op(1'b0, 32'h1000, 32'd4, 8, 2'b10, -1, 0, -1,
             1'b1, {32'h100C, 32'h1008, 32'h1004, 32'h1000});
      // halfword load with a one-lane tail on beat1
      run_op(1'b0, 32'h2000, 32'd2, 5, 2'b01, -1, 0, -1,
             1'b1, {32'h2006, 32'h2004, 32'h2002, 32'h2000});
      // backpressure: three stalled cycles on beat0
      run_op(1'b0, 32'h3000, 32'd4, 4, 2'b10, 0, 3, -1, 1'b0, '0);
      // misaligned fault on beat1 of three
      run_op(1'b0, 32'h4000, 32'd8, 12, 2'b10, -1, 0, 1, 1'b0, '0);
      // empty store
      run_op(1'b1, 32'h7000, 32'd4, 0, 2'b10, -1, 0, -1, 1'b0, '0);
      // byte store, negative stride wrapping below zero, lane3 masked
      run_op(1'b1, 32'h0, 32'hFFFF_FFFC, 3, 2'b00, -1, 0, -1,
             1'b1, {32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0});
      // zero stride store with a stall on beat1
      run_op(1'b1, 32'h8000, 32'd0, 6, 2'b10, 1, 2, -1,
             1'b1, {32'h8000, 32'h8000, 32'h8000, 32'h8000});

      // reset in the middle of ISSUE
      accept(1'b0, 32'h5000, 32'd4, 8, 2'b10);
      chk("mid_issue_ren", lsc_ren, 1'b1);
      @(posedge CLK); #2;
      RST = 1'b1; #1;
      chk("mid_rst_ren_wen", {lsc_ren, lsc_wen}, 2'b00);
      chk("mid_rst_status",  {wb_valid, done, fault}, 3'b000);
      chk("mid_rst_ready",   req_ready, 1'b0);
      exp_req.delete(); exp_wb.delete(); exp_ev.delete();
      @(negedge CLK); RST = 1'b0; #1;
      chk("post_rst_ready", req_ready, 1'b1);
      @(posedge CLK); #1;
      run_op(1'b0, 32'h6000, 32'd4, 4, 2'b10, -1, 0, -1,
             1'b1, {32'h600C, 32'h6008, 32'h6004, 32'h6000});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
